// File: rtl/buffer_memory_sub_block.sv
// One storage stage of the buffer-memory shift-register FIFO: a data word plus
// its empty flag, loaded together from the upstream stage when write is high.
module buffer_memory_sub_block #(
  parameter int DATA_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_empty,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Power-up value matches the reset state so an unreset stage reads as empty.
  logic [DATA_WIDTH-1:0] data_q  = '0;
  logic                  empty_q = 1'b1;

  // NOTE: non-blocking assignments let every chained stage sample its
  // upstream's pre-edge value, so one edge shifts the chain by exactly one.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      empty_q <= 1'b1;
    end else if (write) begin
      data_q  <= in_data;
      empty_q <= in_empty;
    end
  end

  assign out_data  = data_q;
  assign out_empty = empty_q;

endmodule

// File: tb/tb_buffer_memory_sub_block.sv
// Self-checking bench: directed cases plus randomized traffic on a single stage
// and on a 4-stage chain, compared against a behavioural model.
module tb_buffer_memory_sub_block;

  localparam int W      = 40;
  localparam int STAGES = 4;

  typedef struct packed {
    logic         empty;
    logic [W-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single stage under test
  logic         reset    = 1'b0;
  logic         write    = 1'b0;
  logic         in_empty = 1'b1;
  logic [W-1:0] in_data  = '0;
  logic         out_empty;
  logic [W-1:0] out_data;

  buffer_memory_sub_block #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .in_empty (in_empty),
    .in_data  (in_data),
    .out_empty(out_empty),
    .out_data (out_data)
  );

  // Chain of stages; stage 0 treats a zero word as empty
  logic                    chain_reset = 1'b1;
  logic [W-1:0]            chain_in    = '0;
  wire  [STAGES:0]         ce;
  wire  [STAGES:0][W-1:0]  cd;

  assign cd[0] = chain_in;
  assign ce[0] = (chain_in == '0);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_chain
    buffer_memory_sub_block #(.DATA_WIDTH(W)) u_stage (
      .clk      (clk),
      .reset    (chain_reset),
      .write    (1'b1),
      .in_empty (ce[gi]),
      .in_data  (cd[gi]),
      .out_empty(ce[gi+1]),
      .out_data (cd[gi+1])
    );
  end

  // Reference model: the stage remembers the last accepted entry; the chain is
  // a fixed-length queue where index 0 is the stage nearest the input.
  entry_t exp_stage;
  entry_t exp_chain[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic compare_all();
    check("stage_data", out_data, exp_stage.data);
    check("stage_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, exp_stage.empty});
    for (int k = 0; k < STAGES; k++) begin
      check($sformatf("chain%0d_data", k), cd[k+1], exp_chain[k].data);
      check($sformatf("chain%0d_empty", k), {{(W-1){1'b0}}, ce[k+1]},
            {{(W-1){1'b0}}, exp_chain[k].empty});
    end
  endtask

  // Advance the model with the pre-edge inputs, take one edge, then compare.
  task automatic tick();
    if (reset)      exp_stage = '{empty: 1'b1, data: '0};
    else if (write) exp_stage = '{empty: in_empty, data: in_data};
    if (chain_reset) begin
      foreach (exp_chain[k]) exp_chain[k] = '{empty: 1'b1, data: '0};
    end else begin
      exp_chain.push_front('{empty: (chain_in == '0), data: chain_in});
      void'(exp_chain.pop_back());
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    exp_stage = '{empty: 1'b1, data: '0};
    for (int k = 0; k < STAGES; k++) exp_chain.push_back('{empty: 1'b1, data: '0});

    // Power-up state before any edge
    #1;
    check("powerup_data", out_data, '0);
    check("powerup_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});

    // Preload then reset
    write = 1'b1; in_empty = 1'b0; in_data = 40'hAB_CDEF_0123;
    tick();
    chain_reset = 1'b0;
    check("preload", out_data, 40'hAB_CDEF_0123);
    reset = 1'b1;
    tick();
    check("reset_data", out_data, '0);
    check("reset_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});

    // Load: outputs unchanged until the edge
    reset = 1'b0; write = 1'b1; in_empty = 1'b0; in_data = 40'h12_3456_789A;
    #1;
    check("load_pre_data", out_data, '0);
    check("load_pre_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});
    tick();
    check("load_data", out_data, 40'h12_3456_789A);
    check("load_empty", {{(W-1){1'b0}}, out_empty}, '0);

    // Hold for 5 edges with hostile inputs
    write = 1'b0; in_empty = 1'b1; in_data = 40'hFF_FFFF_FFFF;
    repeat (5) begin
      tick();
      check("hold_data", out_data, 40'h12_3456_789A);
      check("hold_empty", {{(W-1){1'b0}}, out_empty}, '0);
    end

    // Empty propagation over a valid word
    write = 1'b1; in_empty = 1'b1; in_data = '0;
    tick();
    check("prop_data", out_data, '0);
    check("prop_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});

    // Zero word stored as valid, nonzero word stored as empty
    in_empty = 1'b0; in_data = '0;
    tick();
    check("zero_valid", {{(W-1){1'b0}}, out_empty}, '0);
    in_empty = 1'b1; in_data = 40'h00_0000_BEEF;
    tick();
    check("nonzero_empty_data", out_data, 40'h00_0000_BEEF);
    check("nonzero_empty_flag", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});

    // Reset beats write
    in_empty = 1'b0; in_data = 40'h0F_0F0F_0F0F;
    tick();
    reset = 1'b1; write = 1'b1; in_data = 40'h55_5555_5555; in_empty = 1'b0;
    tick();
    check("rst_prio_data", out_data, '0);
    check("rst_prio_empty", {{(W-1){1'b0}}, out_empty}, {{(W-1){1'b0}}, 1'b1});
    reset = 1'b0;

    // Chain: 1,2,3,4 then 0
    chain_reset = 1'b1;
    tick();
    chain_reset = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      chain_in = W'(v);
      tick();
    end
    for (int k = 0; k < STAGES; k++) begin
      check($sformatf("chain_fill%0d", k), cd[k+1], W'(4 - k));
      check($sformatf("chain_fill%0d_e", k), {{(W-1){1'b0}}, ce[k+1]}, '0);
    end
    chain_in = '0;
    tick();
    check("chain_shift3", cd[4], W'(2));
    check("chain_shift0_e", {{(W-1){1'b0}}, ce[1]}, {{(W-1){1'b0}}, 1'b1});

    // Randomized traffic on both
    for (int i = 0; i < 300; i++) begin
      reset       = ($urandom_range(15) == 0);
      write       = $urandom_range(1);
      in_empty    = $urandom_range(1);
      in_data     = ($urandom_range(7) == 0) ? '0 : rand_word();
      chain_reset = ($urandom_range(31) == 0);
      chain_in    = ($urandom_range(3) == 0) ? '0 : rand_word();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
